// File: rtl/control_pkg.sv
// control_pkg -- shared types and constants for the control unit.
//   state_t  : 4-bit FSM state encoding (also driven on OutState)
//   opcode_t : 4-bit opcode field IR[15:12]
//   ALU_*    : ALU operation select values for ALU_s0
// Optional feature macro: CU_SINGLE_STEP_EN adds the STEP_WAIT state.
package control_pkg;

  typedef enum logic [3:0] {
    S_INIT      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_NOOP      = 4'd3,
    S_LOAD_A    = 4'd4,
    S_LOAD_B    = 4'd5,
    S_STORE     = 4'd6,
    S_ADD       = 4'd7,
    S_SUB       = 4'd8,
    S_HALT      = 4'd9
`ifdef CU_SINGLE_STEP_EN
    ,
    S_STEP_WAIT = 4'd10
`endif
  } state_t;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'd0,
    OP_STORE = 4'd1,
    OP_LOAD  = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_HALT  = 4'd5
  } opcode_t;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

  // Where a completed instruction goes: straight to FETCH, or parked in
  // STEP_WAIT until the operator pulses Step.
`ifdef CU_SINGLE_STEP_EN
  localparam state_t S_RETURN = S_STEP_WAIT;
`else
  localparam state_t S_RETURN = S_FETCH;
`endif

endpackage

// File: rtl/instr_decode.sv
// instr_decode -- purely combinational field extraction and opcode decode.
// Ports:
//   ir_i         [15:0]  instruction register contents
//   op_state_o   [3:0]   state to enter after DECODE (state_t encoding)
//   ra_o / rb_o  [RA_W]  register read addresses IR[11:8] / IR[7:4]
//   rw_o         [RA_W]  register write address IR[3:0]
//   load_addr_o  [DA_W]  LOAD data address IR[11:4]
//   store_addr_o [DA_W]  STORE data address IR[7:0]
module instr_decode
  import control_pkg::*;
#(
  parameter int DA_W = 8,
  parameter int RA_W = 4
) (
  input  logic [15:0]     ir_i,
  output logic [3:0]      op_state_o,
  output logic [RA_W-1:0] ra_o,
  output logic [RA_W-1:0] rb_o,
  output logic [RA_W-1:0] rw_o,
  output logic [DA_W-1:0] load_addr_o,
  output logic [DA_W-1:0] store_addr_o
);

  // Fields are fixed-width in the instruction; resize to the configured
  // address widths (zero-extend or truncate).
  assign ra_o         = RA_W'(ir_i[11:8]);
  assign rb_o         = RA_W'(ir_i[7:4]);
  assign rw_o         = RA_W'(ir_i[3:0]);
  assign load_addr_o  = DA_W'(ir_i[11:4]);
  assign store_addr_o = DA_W'(ir_i[7:0]);

  // Undefined opcodes 6..15 fall through to NOOP.
  always_comb begin
    op_state_o = S_NOOP;
    case (ir_i[15:12])
      OP_STORE: op_state_o = S_STORE;
      OP_LOAD:  op_state_o = S_LOAD_A;
      OP_ADD:   op_state_o = S_ADD;
      OP_SUB:   op_state_o = S_SUB;
      OP_HALT:  op_state_o = S_HALT;
      default:  op_state_o = S_NOOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit -- Moore FSM controller for a small load/store datapath.
// Ports:
//   Clock, Clr          clock and synchronous active-high reset
//   IR[15:0]            current instruction
//   PC_Clr, PC_Up       program counter clear / increment
//   IR_Ld               instruction register load
//   D_Addr, D_Wr        data memory address / write enable
//   RF_s                register write mux (1 = memory, 0 = ALU)
//   RF_W_Addr, RF_W_En  register write address / enable
//   RF_Ra_Addr, RF_Rb_Addr  register read addresses
//   ALU_s0[2:0]         ALU op (0 pass, 1 add, 2 sub)
//   OutState[3:0]       current state encoding
//   Halted              high in HALT
//   Step                (CU_SINGLE_STEP_EN only) advance from STEP_WAIT
// Optional feature macro: CU_SINGLE_STEP_EN.
module control_unit
  import control_pkg::*;
#(
  parameter int DA_W = 8,
  parameter int RA_W = 4
) (
  input  logic            Clock,
  input  logic            Clr,
  input  logic [15:0]     IR,
`ifdef CU_SINGLE_STEP_EN
  input  logic            Step,
`endif
  output logic            PC_Clr,
  output logic            PC_Up,
  output logic            IR_Ld,
  output logic [DA_W-1:0] D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [RA_W-1:0] RF_W_Addr,
  output logic            RF_W_En,
  output logic [RA_W-1:0] RF_Ra_Addr,
  output logic [RA_W-1:0] RF_Rb_Addr,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      OutState,
  output logic            Halted
);

  state_t          state_q, state_d;
  logic [3:0]      op_state_raw;
  state_t          op_state;
  logic [RA_W-1:0] ra, rb, rw;
  logic [DA_W-1:0] load_addr, store_addr;

  instr_decode #(
    .DA_W (DA_W),
    .RA_W (RA_W)
  ) u_decode (
    .ir_i         (IR),
    .op_state_o   (op_state_raw),
    .ra_o         (ra),
    .rb_o         (rb),
    .rw_o         (rw),
    .load_addr_o  (load_addr),
    .store_addr_o (store_addr)
  );

  assign op_state = state_t'(op_state_raw);

  // Clr wins over every transition, including HALT and mid-LOAD.
  always_ff @(posedge Clock) begin
    if (Clr) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = op_state;
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_RETURN;
      S_HALT:   state_d = S_HALT;
`ifdef CU_SINGLE_STEP_EN
      S_STEP_WAIT: if (Step) state_d = S_FETCH;
`endif
      default:  state_d = S_INIT;
    endcase
  end

  // Moore outputs: depend only on state_q and IR fields.
  always_comb begin
    PC_Clr     = 1'b0;
    PC_Up      = 1'b0;
    IR_Ld      = 1'b0;
    D_Addr     = '0;
    D_Wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_Addr  = '0;
    RF_W_En    = 1'b0;
    RF_Ra_Addr = '0;
    RF_Rb_Addr = '0;
    ALU_s0     = ALU_PASS;
    Halted     = 1'b0;
    case (state_q)
      S_INIT: PC_Clr = 1'b1;
      S_FETCH: begin
        PC_Up = 1'b1;
        IR_Ld = 1'b1;
      end
      // LOAD_A presents the address so synchronous memory data is ready
      // for the register write in LOAD_B.
      S_LOAD_A: D_Addr = load_addr;
      S_LOAD_B: begin
        D_Addr    = load_addr;
        RF_s      = 1'b1;
        RF_W_Addr = rw;
        RF_W_En   = 1'b1;
      end
      S_STORE: begin
        D_Addr     = store_addr;
        RF_Ra_Addr = ra;
        D_Wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr = ra;
        RF_Rb_Addr = rb;
        RF_W_Addr  = rw;
        RF_W_En    = 1'b1;
        ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  assign OutState = state_q;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit -- self-checking bench for control_unit.
// Each stimulus entry drives Clr/Step/IR before an edge and names the state
// expected after it; the expected output vector is pushed to a scoreboard
// and popped for comparison #1 after the edge.
module tb_control_unit;

  localparam logic [3:0] ST_INIT = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                         ST_NOOP = 4'd3, ST_LOAD_A = 4'd4, ST_LOAD_B = 4'd5,
                         ST_STORE = 4'd6, ST_ADD = 4'd7, ST_SUB = 4'd8,
                         ST_HALT = 4'd9, ST_STEP = 4'd10;

  logic        Clock = 1'b0;
  logic        Clr = 1'b1;
  logic [15:0] IR = 16'h0000;
`ifdef CU_SINGLE_STEP_EN
  logic        Step = 1'b0;
`endif
  logic        PC_Clr, PC_Up, IR_Ld, D_Wr, RF_s, RF_W_En, Halted;
  logic [7:0]  D_Addr;
  logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, OutState;
  logic [2:0]  ALU_s0;

  control_unit #(.DA_W(8), .RA_W(4)) dut (
    .Clock      (Clock),
    .Clr        (Clr),
    .IR         (IR),
`ifdef CU_SINGLE_STEP_EN
    .Step       (Step),
`endif
    .PC_Clr     (PC_Clr),
    .PC_Up      (PC_Up),
    .IR_Ld      (IR_Ld),
    .D_Addr     (D_Addr),
    .D_Wr       (D_Wr),
    .RF_s       (RF_s),
    .RF_W_Addr  (RF_W_Addr),
    .RF_W_En    (RF_W_En),
    .RF_Ra_Addr (RF_Ra_Addr),
    .RF_Rb_Addr (RF_Rb_Addr),
    .ALU_s0     (ALU_s0),
    .OutState   (OutState),
    .Halted     (Halted)
  );

  always #5 Clock = ~Clock;

  logic [33:0] outs;
  assign outs = {OutState, PC_Clr, PC_Up, IR_Ld, D_Addr, D_Wr, RF_s,
                 RF_W_Addr, RF_W_En, RF_Ra_Addr, RF_Rb_Addr, ALU_s0, Halted};

  typedef struct {
    logic        clr;
    logic        step;
    logic [15:0] ir;
    logic [3:0]  st;
  } stim_t;

  stim_t       stim_q[$];
  logic [33:0] sb_q[$];
  int          errors = 0;
  int          checks = 0;

  // Expected outputs from the state/output table for a given state and IR.
  function automatic logic [33:0] model(input logic [3:0] st, input logic [15:0] ir);
    logic       pc_clr, pc_up, ir_ld, d_wr, rf_s, we, halt;
    logic [7:0] da;
    logic [3:0] wa, ra, rb;
    logic [2:0] alu;
    pc_clr = 0; pc_up = 0; ir_ld = 0; d_wr = 0; rf_s = 0; we = 0; halt = 0;
    da = 0; wa = 0; ra = 0; rb = 0; alu = 0;
    case (st)
      ST_INIT:   pc_clr = 1;
      ST_FETCH:  begin pc_up = 1; ir_ld = 1; end
      ST_LOAD_A: da = ir[11:4];
      ST_LOAD_B: begin da = ir[11:4]; rf_s = 1; wa = ir[3:0]; we = 1; end
      ST_STORE:  begin da = ir[7:0]; ra = ir[11:8]; d_wr = 1; end
      ST_ADD:    begin ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; we = 1; alu = 3'd1; end
      ST_SUB:    begin ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; we = 1; alu = 3'd2; end
      ST_HALT:   halt = 1;
      default: ;
    endcase
    return {st, pc_clr, pc_up, ir_ld, da, d_wr, rf_s, wa, we, ra, rb, alu, halt};
  endfunction

  task automatic push(input logic clr, input logic step, input logic [15:0] ir,
                      input logic [3:0] st);
    stim_t s;
    s.clr = clr; s.step = step; s.ir = ir; s.st = st;
    stim_q.push_back(s);
  endtask

  // Queue the state walk of one instruction, starting from FETCH.
  task automatic add_instr(input logic [15:0] ir);
    logic [3:0] op;
    op = ir[15:12];
    push(0, 1, ir, ST_DECODE);
    case (op)
      4'd1: push(0, 1, ir, ST_STORE);
      4'd2: begin push(0, 1, ir, ST_LOAD_A); push(0, 1, ir, ST_LOAD_B); end
      4'd3: push(0, 1, ir, ST_ADD);
      4'd4: push(0, 1, ir, ST_SUB);
      4'd5: push(0, 1, ir, ST_HALT);
      default: push(0, 1, ir, ST_NOOP);
    endcase
    if (op != 4'd5) begin
`ifdef CU_SINGLE_STEP_EN
      push(0, 0, ir, ST_STEP);
`endif
      push(0, 1, ir, ST_FETCH);
    end
  endtask

  task automatic test_reset;
    stim_t s; logic [33:0] exp;
    push(1, 0, 16'h0000, ST_INIT);
    push(1, 0, 16'h0000, ST_INIT);
    push(0, 0, 16'h0000, ST_FETCH);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      Clr = s.clr; IR = s.ir;
`ifdef CU_SINGLE_STEP_EN
      Step = s.step;
`endif
      sb_q.push_back(model(s.st, s.ir));
      @(posedge Clock); #1;
      exp = sb_q.pop_front(); checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL reset st=%0d got=%h want=%h", s.st, outs, exp);
      end else $display("ok   reset st=%0d out=%h", OutState, outs);
    end
  endtask

  task automatic test_load;
    stim_t s; logic [33:0] exp;
    add_instr(16'h21B3);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      Clr = s.clr; IR = s.ir;
`ifdef CU_SINGLE_STEP_EN
      Step = s.step;
`endif
      sb_q.push_back(model(s.st, s.ir));
      @(posedge Clock); #1;
      exp = sb_q.pop_front(); checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL load st=%0d got=%h want=%h", s.st, outs, exp);
      end else $display("ok   load st=%0d out=%h", OutState, outs);
      if (s.st == ST_LOAD_B) begin
        checks++;
        if ({D_Addr, RF_W_Addr, RF_s, RF_W_En} !== {8'h1B, 4'd3, 1'b1, 1'b1}) begin
          errors++; $display("FAIL load_b_fields got=%h want=%h",
                             {D_Addr, RF_W_Addr, RF_s, RF_W_En}, {8'h1B, 4'd3, 1'b1, 1'b1});
        end
      end
    end
  endtask

  task automatic test_alu;
    stim_t s; logic [33:0] exp;
    add_instr(16'h3257);
    add_instr(16'h4257);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      Clr = s.clr; IR = s.ir;
`ifdef CU_SINGLE_STEP_EN
      Step = s.step;
`endif
      sb_q.push_back(model(s.st, s.ir));
      @(posedge Clock); #1;
      exp = sb_q.pop_front(); checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL alu st=%0d got=%h want=%h", s.st, outs, exp);
      end else $display("ok   alu st=%0d out=%h", OutState, outs);
      if (s.st == ST_ADD || s.st == ST_SUB) begin
        checks++;
        if ({RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, RF_W_En, ALU_s0} !==
            {4'd2, 4'd5, 4'd7, 1'b1, (s.st == ST_ADD) ? 3'd1 : 3'd2}) begin
          errors++; $display("FAIL alu_fields st=%0d got=%h alu=%0d", s.st,
                             {RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, RF_W_En}, ALU_s0);
        end
      end
    end
  endtask

  task automatic test_store_noop;
    stim_t s; logic [33:0] exp;
    add_instr(16'h1420);
    add_instr(16'hF000);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      Clr = s.clr; IR = s.ir;
`ifdef CU_SINGLE_STEP_EN
      Step = s.step;
`endif
      sb_q.push_back(model(s.st, s.ir));
      @(posedge Clock); #1;
      exp = sb_q.pop_front(); checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL store_noop st=%0d got=%h want=%h", s.st, outs, exp);
      end else $display("ok   store_noop st=%0d out=%h", OutState, outs);
      if (s.st == ST_STORE) begin
        checks++;
        if ({D_Wr, D_Addr, RF_Ra_Addr, RF_W_En} !== {1'b1, 8'h20, 4'd4, 1'b0}) begin
          errors++; $display("FAIL store_fields got=%h want=%h",
                             {D_Wr, D_Addr, RF_Ra_Addr, RF_W_En}, {1'b1, 8'h20, 4'd4, 1'b0});
        end
      end
      if (s.ir == 16'hF000 && s.st != ST_FETCH) begin
        checks++;
        if ({D_Wr, RF_W_En} !== 2'b00) begin
          errors++; $display("FAIL noop_strobes st=%0d got=%b want=00", s.st, {D_Wr, RF_W_En});
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    stim_t s; logic [33:0] exp; logic [15:0] ir; int pcup;
    pcup = 0;
    for (int i = 0; i < 24; i++) begin
      ir = 16'($urandom);
      if (ir[15:12] == 4'd5) ir[15:12] = 4'd6;
      add_instr(ir);
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      Clr = s.clr; IR = s.ir;
`ifdef CU_SINGLE_STEP_EN
      Step = s.step;
`endif
      sb_q.push_back(model(s.st, s.ir));
      @(posedge Clock); #1;
      if (PC_Up === 1'b1) pcup++;
      exp = sb_q.pop_front(); checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL b2b ir=%h st=%0d got=%h want=%h", s.ir, s.st, outs, exp);
      end else $display("ok   b2b ir=%h st=%0d out=%h", s.ir, OutState, outs);
    end
    checks++;
    if (pcup !== 24) begin
      errors++; $display("FAIL pc_up_count got=%0d want=24", pcup);
    end
  endtask

  task automatic test_clr_mid_load;
    stim_t s; logic [33:0] exp;
    push(0, 1, 16'h2AB9, ST_DECODE);
    push(0, 1, 16'h2AB9, ST_LOAD_A);
    push(1, 1, 16'h2AB9, ST_INIT);
    push(0, 1, 16'h2AB9, ST_FETCH);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      Clr = s.clr; IR = s.ir;
`ifdef CU_SINGLE_STEP_EN
      Step = s.step;
`endif
      sb_q.push_back(model(s.st, s.ir));
      @(posedge Clock); #1;
      exp = sb_q.pop_front(); checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL clr_mid_load st=%0d got=%h want=%h", s.st, outs, exp);
      end else $display("ok   clr_mid_load st=%0d out=%h", OutState, outs);
      checks++;
      if ({RF_W_En, D_Wr} !== 2'b00) begin
        errors++; $display("FAIL clr_mid_load_strobe st=%0d got=%b want=00", s.st, {RF_W_En, D_Wr});
      end
    end
  endtask

  task automatic test_halt;
    stim_t s; logic [33:0] exp;
    add_instr(16'h5000);
    for (int i = 0; i < 11; i++) push(0, 1, 16'h5000, ST_HALT);
    push(1, 1, 16'h5000, ST_INIT);
    push(0, 1, 16'h0000, ST_FETCH);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      Clr = s.clr; IR = s.ir;
`ifdef CU_SINGLE_STEP_EN
      Step = s.step;
`endif
      sb_q.push_back(model(s.st, s.ir));
      @(posedge Clock); #1;
      exp = sb_q.pop_front(); checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL halt st=%0d got=%h want=%h", s.st, outs, exp);
      end else $display("ok   halt st=%0d out=%h", OutState, outs);
      if (s.st == ST_HALT) begin
        checks++;
        if ({Halted, PC_Up} !== 2'b10) begin
          errors++; $display("FAIL halt_hold got=%b want=10", {Halted, PC_Up});
        end
      end
    end
  endtask

`ifdef CU_SINGLE_STEP_EN
  task automatic test_single_step;
    stim_t s; logic [33:0] exp; int fetches;
    fetches = 0;
    push(0, 0, 16'h0000, ST_DECODE);
    push(0, 0, 16'h0000, ST_NOOP);
    for (int i = 0; i < 6; i++) push(0, 0, 16'h0000, ST_STEP);
    push(0, 1, 16'h0000, ST_FETCH);
    push(0, 0, 16'h0000, ST_DECODE);
    push(0, 0, 16'h0000, ST_NOOP);
    push(0, 0, 16'h0000, ST_STEP);
    push(0, 0, 16'h0000, ST_STEP);
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      Clr = s.clr; IR = s.ir; Step = s.step;
      sb_q.push_back(model(s.st, s.ir));
      @(posedge Clock); #1;
      if (OutState === ST_FETCH) fetches++;
      exp = sb_q.pop_front(); checks++;
      if (outs !== exp) begin
        errors++; $display("FAIL single_step st=%0d got=%h want=%h", s.st, outs, exp);
      end else $display("ok   single_step st=%0d out=%h", OutState, outs);
    end
    checks++;
    if (fetches !== 1) begin
      errors++; $display("FAIL single_step_fetches got=%0d want=1", fetches);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_alu();
    test_store_noop();
    test_back_to_back();
    test_clr_mid_load();
    test_halt();
`ifdef CU_SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter DA_W, default 8: data-memory address width.
REQ-002 The block SHALL have parameter RA_W, default 4: register-file address width.
REQ-003 Port Clock, input, 1: single clock; all state changes on posedge.
REQ-004 Port Clr, input, 1: reset, synchronous, active-high.
REQ-005 Port IR, input, 16: current instruction register contents.
REQ-006 Port PC_Clr, output, 1: clears the program counter.
REQ-007 Port PC_Up, output, 1: increments the program counter.
REQ-008 Port IR_Ld, output, 1: loads the instruction register from instruction memory.
REQ-009 Port D_Addr, output, DA_W: data-memory address.
REQ-010 Port D_Wr, output, 1: data-memory write enable.
REQ-011 Port RF_s, output, 1: register-file write-data mux select; 1 = memory, 0 = ALU.
REQ-012 Port RF_W_Addr, output, RA_W: register-file write address.
REQ-013 Port RF_W_En, output, 1: register-file write enable.
REQ-014 Port RF_Ra_Addr / RF_Rb_Addr, output, RA_W each: register-file read addresses.
REQ-015 Port ALU_s0, output, 3: ALU operation select; 0 = pass A, 1 = add, 2 = sub.
REQ-016 Port OutState, output, 4: current state encoding for display.
REQ-017 Port Halted, output, 1: high while in HALT.

Function
REQ-018 Opcode IR[15:12] SHALL be decoded as follows:
- 0 NOOP
- 1 STORE: D[IR[7:0]] <= R[IR[11:8]]
- 2 LOAD: R[IR[3:0]] <= D[IR[11:4]]
- 3 ADD: R[IR[3:0]] <= R[IR[11:8]] + R[IR[7:4]]
- 4 SUB: R[IR[3:0]] <= R[IR[11:8]] - R[IR[7:4]]
- 5 HALT
- 6..15 SHALL execute as NOOP.
REQ-019 States SHALL be INIT=0, FETCH=1, DECODE=2, NOOP=3, LOAD_A=4, LOAD_B=5, STORE=6, ADD=7, SUB=8, HALT=9, with OutState = encoding.
REQ-020 State transitions SHALL be:
- INIT->FETCH
- FETCH->DECODE
- DECODE->op state
- LOAD_A->LOAD_B
- NOOP/LOAD_B/STORE/ADD/SUB->FETCH
- HALT->HALT until Clr.
REQ-021 Outputs SHALL be Moore (functions of state and IR only), with every output 0 except as listed:
- INIT: PC_Clr=1
- FETCH: PC_Up=1, IR_Ld=1
- LOAD_A: D_Addr=IR[11:4]
- LOAD_B: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0], RF_W_En=1
- STORE: D_Addr=IR[7:0], RF_Ra_Addr=IR[11:8], D_Wr=1
- ADD/SUB: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_W_En=1, ALU_s0=1 (ADD) or 2 (SUB)
- HALT: Halted=1.
REQ-022 Instruction latency SHALL be 3 cycles for NOOP/STORE/ADD/SUB, 4 cycles for LOAD, and 2 cycles to reach HALT (FETCH to FETCH).
REQ-023 PC wrap from 127 to 0 SHALL need no special handling; the controller keeps fetching.
REQ-024 PC_Up SHALL be high for exactly one cycle per instruction.

Reset
REQ-025 Clr=1 at a clock edge SHALL force the state to INIT from any state, overriding all transitions including HALT and mid-LOAD.
REQ-026 Output values while in INIT SHALL be: PC_Clr=1, OutState=0, all other outputs 0; D_Wr and RF_W_En SHALL never be asserted in INIT.

Configuration
REQ-027 With CU_SINGLE_STEP_EN defined, the block SHALL add input Step (1 bit) and state STEP_WAIT=10.
- Every path that returns to FETCH SHALL go to STEP_WAIT instead.
- STEP_WAIT SHALL advance to FETCH on the edge where Step=1 and hold otherwise.
- All outputs SHALL be 0 in STEP_WAIT.
REQ-028 Without CU_SINGLE_STEP_EN, the Step port and STEP_WAIT SHALL NOT exist, and timing SHALL be as in REQ-022.

Structure
REQ-029 Package control_pkg SHALL hold the state_t enum (4-bit), the opcode_t enum (4-bit), and the ALU select constants.
REQ-030 Combinational field extraction and opcode decoding SHALL live in sub-module instr_decode; control_unit holds the state register and the output logic.

Verification
REQ-031 Clr=1 for 2 cycles, then 0 -> OutState 0 with PC_Clr=1; next cycle FETCH with PC_Up=IR_Ld=1.
REQ-032 IR=16'h2_1B_3 (LOAD) -> states FETCH, DECODE, LOAD_A, LOAD_B; in LOAD_B: D_Addr=8'h1B, RF_W_Addr=3, RF_s=1, RF_W_En=1.
REQ-033 IR=16'h3_2_5_7 (ADD) -> ADD state: Ra=2, Rb=5, RF_W_Addr=7, ALU_s0=1, RF_W_En=1; IR=16'h4257 gives ALU_s0=2.
REQ-034 IR=16'h1_4_20 (STORE) -> D_Wr=1, D_Addr=8'h20, RF_Ra_Addr=4, RF_W_En=0; IR=16'hF000 -> NOOP path with no write strobes.
REQ-035 IR=16'h5000 (HALT) -> Halted=1 for 10+ cycles with PC_Up=0; Clr=1 -> INIT next edge; Clr asserted during LOAD_A -> INIT with no RF write.
REQ-036 With CU_SINGLE_STEP_EN defined: Step held 0 -> STEP_WAIT held after each instruction; a 1-cycle Step pulse -> exactly one FETCH.
